seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares a single BCD-to-7-segment decoder across four digits by cycling a digit index at a fixed refresh rate. It drives active-low segment and digit-enable lines and inserts a guard blank at every digit switch to suppress ghosting. A new 4-digit BCD value is accepted through a valid/ready handshake and applied only at a frame boundary, so frames never tear.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_scan_ctrl_dec.sv | 18 +
 rtl/seg7_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan controller.
//   NDIG        - number of multiplexed digits
//   SEG_BLANK   - active-low pattern with every segment off
//   SEG_DIGITS  - active-low Y6..Y0 patterns for BCD 0..9
//   slot_state_e- per-slot state: guard blank, then digit shown
package seg7_pkg;

    localparam int unsigned NDIG = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h58, 7'h00, 7'h10
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// seg7_scan_ctrl_dec: BCD to active-low 7-segment decoder.
//   i_bcd - BCD nibble
//   o_seg - segments Y6..Y0, active-low; value for A..F is a don't-care
module seg7_scan_ctrl_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = '0;
        if (i_bcd < 4'd10) begin
            o_seg = SEG_DIGITS[i_bcd];
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode 7-segment scan controller.
// One shared decoder, guard blank at each digit switch, new values taken
// through valid/ready and applied only at frame start.
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - display enable (low blanks pins, timing keeps running)
//   load_valid  - new 16-bit BCD value offered on value
//   load_ready  - a new value can be accepted
//   value       - four BCD digits, value[3:0] is digit 0 (rightmost)
//   seg         - segments Y6..Y0, active-low, registered
//   an          - digit enables, active-low, registered
//   frame_done  - one-cycle pulse for the last cycle of each frame
// Optional: define LEAD_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] value,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GLAST = CW'(GUARD - 1);

    logic [CW-1:0]          r_cnt;
    logic [1:0]             r_dig;
    slot_state_e            r_state;
    slot_state_e            w_state_nxt;
    logic [15:0]            r_disp;
    logic [15:0]            r_pend;
    logic                   r_pf;
    logic [6:0]             r_seg;
    logic [3:0]             r_an;
    logic                   r_frame_done;

    logic                   w_cnt_wrap;
    logic                   w_frame_start;
    logic                   w_frame_end;
    logic                   w_xfer;
    logic [3:0]             w_nib;
    logic [6:0]             w_dec_seg;
    logic                   w_lz_blank;
    logic [6:0]             w_seg_d;
    logic [3:0]             w_an_d;

    assign w_cnt_wrap    = (r_cnt == CNT_LAST);
    assign w_frame_start = (r_dig == 2'd0) && (r_cnt == '0);
    assign w_frame_end   = (r_dig == 2'd3) && w_cnt_wrap;
    assign w_xfer        = load_valid && !r_pf;
    assign load_ready    = !r_pf;

    // Slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_dig <= r_dig + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Slot FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot FSM: next state; state always tracks (cnt >= GUARD)
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BLANK: if (r_cnt == CNT_GLAST) w_state_nxt = SHOW;
            SHOW:  if (w_cnt_wrap)         w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase
    end

    // Pending register and frame-boundary apply; transfer needs !pf, so
    // apply and transfer never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_pend <= '0;
            r_pf   <= 1'b0;
        end else begin
            if (w_frame_start && r_pf) begin
                r_disp <= r_pend;
                r_pf   <= 1'b0;
            end
            if (w_xfer) begin
                r_pend <= value;
                r_pf   <= 1'b1;
            end
        end
    end

    assign w_nib = r_disp[{r_dig, 2'b00} +: 4];

    seg7_scan_ctrl_dec u_dec (
        .i_bcd (w_nib),
        .o_seg (w_dec_seg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        w_lz_blank = 1'b0;
        unique case (r_dig)
            2'd3:    w_lz_blank = (r_disp[15:12] == 4'd0);
            2'd2:    w_lz_blank = (r_disp[15:8]  == 8'd0);
            2'd1:    w_lz_blank = (r_disp[15:4]  == 12'd0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Slot FSM: outputs, with blank / non-BCD override
    always_comb begin
        w_seg_d = SEG_BLANK;
        w_an_d  = '1;
        if ((r_state == SHOW) && en && !w_lz_blank) begin
            w_an_d  = ~(4'b0001 << r_dig);
            w_seg_d = (w_nib <= 4'd9) ? w_dec_seg : SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_BLANK;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_d;
            r_an         <= w_an_d;
            r_frame_done <= w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
